// File: rtl/riscv_mmu_pkg.sv
// Shared constants and types for the MMU privilege guard and its debug unlock FSM.
package riscv_mmu_pkg;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_RSVD    = 2'd2;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_CHECK,
    ST_ACTIVE,
    ST_LOCKOUT
  } dbg_state_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_KEY_W       = 32;
  localparam int DEF_MAX_FAIL    = 3;
  localparam int DEF_TIMEOUT_CYC = 1024;

  // Widths sized for the largest legal MAX_FAIL (15) and TIMEOUT_CYC (65535).
  localparam int FAIL_W = 4;
  localparam int TMR_W  = 16;

endpackage

// File: rtl/riscv_dbg_unlock_fsm.sv
// Debug unlock FSM: one-cycle key check, bounded debug session, permanent lockout
// after MAX_FAIL consecutive wrong keys.
module riscv_dbg_unlock_fsm
  import riscv_mmu_pkg::*;
#(
  parameter int KEY_W       = DEF_KEY_W,
  parameter int MAX_FAIL    = DEF_MAX_FAIL,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dbg_req_i,
  input  logic [KEY_W-1:0] dbg_key_i,
  input  logic [KEY_W-1:0] dbg_key_ref_i,
  input  logic             dbg_exit_i,
  output dbg_state_e       state_o,
  output logic             dbg_mode_o,
  output logic             dbg_lockout_o
);

  dbg_state_e        state_q, state_d;
  logic [FAIL_W-1:0] failCnt_q, failCnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [KEY_W-1:0]  key_q, key_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_LOCKED;
      failCnt_q <= '0;
      timer_q   <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      failCnt_q <= failCnt_d;
      timer_q   <= timer_d;
      key_q     <= key_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    failCnt_d = failCnt_q;
    timer_d   = timer_q;
    key_d     = key_q;
    case (state_q)
      ST_LOCKED: begin
        if (dbg_req_i) begin
          state_d = ST_CHECK;
          key_d   = dbg_key_i;
        end
      end
      ST_CHECK: begin
        if (key_q == dbg_key_ref_i) begin
          state_d   = ST_ACTIVE;
          failCnt_d = '0;
          timer_d   = TMR_W'(TIMEOUT_CYC - 1);
        end else begin
          failCnt_d = failCnt_q + FAIL_W'(1);
          state_d   = (failCnt_d == FAIL_W'(MAX_FAIL)) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      // Timer expiry and an explicit exit collapse into the same single return.
      ST_ACTIVE: begin
        if (timer_q == '0 || dbg_exit_i) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_LOCKOUT: state_d = ST_LOCKOUT;
      default:    state_d = ST_LOCKED;
    endcase
  end

  assign state_o       = state_q;
  assign dbg_mode_o    = (state_q == ST_ACTIVE);
  assign dbg_lockout_o = (state_q == ST_LOCKOUT);

endmodule

// File: rtl/riscv_mmu_priv_guard.sv
// Per-channel privilege resolution for MMU translation requests, with a key-gated
// debug override that can promote selected channels to supervisor.
module riscv_mmu_priv_guard
  import riscv_mmu_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter int                KEY_W       = DEF_KEY_W,
  parameter int                MAX_FAIL    = DEF_MAX_FAIL,
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [NUM_CH-1:0] DBG_CH_MASK = NUM_CH'(2)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_CH-1:0]   req_valid_i,
  input  logic [2*NUM_CH-1:0] req_priv_i,
  output logic [NUM_CH-1:0]   req_ready_o,
  output logic [NUM_CH-1:0]   resp_valid_o,
  output logic [NUM_CH-1:0]   resp_super_o,
  output logic [NUM_CH-1:0]   resp_fault_o,
  input  logic                dbg_req_i,
  input  logic [KEY_W-1:0]    dbg_key_i,
  input  logic [KEY_W-1:0]    dbg_key_ref_i,
  input  logic                dbg_exit_i,
  output logic                dbg_mode_o,
  output logic                dbg_lockout_o
);

  dbg_state_e dbgState;

  riscv_dbg_unlock_fsm #(
    .KEY_W      (KEY_W),
    .MAX_FAIL   (MAX_FAIL),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_unlock_fsm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dbg_req_i    (dbg_req_i),
    .dbg_key_i    (dbg_key_i),
    .dbg_key_ref_i(dbg_key_ref_i),
    .dbg_exit_i   (dbg_exit_i),
    .state_o      (dbgState),
    .dbg_mode_o   (dbg_mode_o),
    .dbg_lockout_o(dbg_lockout_o)
  );

  assign req_ready_o = '1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0] priv;
    logic       isRsvd, dbgGrant;
    logic       valid_d, super_d, fault_d;
    logic       valid_q, super_q, fault_q;

    // The FSM state is sampled at acceptance, so a session ending this cycle still grants.
    assign priv     = req_priv_i[2*c +: 2];
    assign isRsvd   = (priv == PRIV_RSVD);
    assign dbgGrant = (dbgState == ST_ACTIVE) && DBG_CH_MASK[c];
    assign valid_d  = req_valid_i[c];
    assign fault_d  = req_valid_i[c] && isRsvd;
    assign super_d  = req_valid_i[c] && !isRsvd && ((priv == PRIV_SUPER) || dbgGrant);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        super_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        super_q <= super_d;
        fault_q <= fault_d;
      end
    end

    assign resp_valid_o[c] = valid_q;
    assign resp_super_o[c] = super_q;
    assign resp_fault_o[c] = fault_q;
  end

endmodule

// File: tb/tb_riscv_mmu_priv_guard.sv
// Randomized and directed bench for riscv_mmu_priv_guard, checked against a
// cycle-level behavioural model of the unlock session and privilege rules.
module tb_riscv_mmu_priv_guard;

  localparam int NUM_CH      = 2;
  localparam int KEY_W       = 32;
  localparam int MAX_FAIL    = 3;
  localparam int TIMEOUT_CYC = 4;
  localparam logic [NUM_CH-1:0] DBG_CH_MASK = 2'b10;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b1;
  logic [NUM_CH-1:0]   req_valid_i = '0;
  logic [2*NUM_CH-1:0] req_priv_i = '0;
  logic [NUM_CH-1:0]   req_ready_o;
  logic [NUM_CH-1:0]   resp_valid_o, resp_super_o, resp_fault_o;
  logic                dbg_req_i = 1'b0;
  logic [KEY_W-1:0]    dbg_key_i = '0;
  logic [KEY_W-1:0]    dbg_key_ref_i;
  logic                dbg_exit_i = 1'b0;
  logic                dbg_mode_o, dbg_lockout_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model: remaining session cycles, pending key check, failure tally.
  int          mSessionLeft = 0;
  int          mFails = 0;
  bit          mLockedOut = 1'b0;
  bit          mPending = 1'b0;
  logic [31:0] mKey = '0;
  logic [31:0] keyRef;

  riscv_mmu_priv_guard #(
    .NUM_CH     (NUM_CH),
    .KEY_W      (KEY_W),
    .MAX_FAIL   (MAX_FAIL),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .DBG_CH_MASK(DBG_CH_MASK)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_priv_i   (req_priv_i),
    .req_ready_o  (req_ready_o),
    .resp_valid_o (resp_valid_o),
    .resp_super_o (resp_super_o),
    .resp_fault_o (resp_fault_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_key_i    (dbg_key_i),
    .dbg_key_ref_i(dbg_key_ref_i),
    .dbg_exit_i   (dbg_exit_i),
    .dbg_mode_o   (dbg_mode_o),
    .dbg_lockout_o(dbg_lockout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] eV, input logic [1:0] eS, input logic [1:0] eF);
    checkOutput({tag, ".ready"},   32'(req_ready_o),   32'h3);
    checkOutput({tag, ".valid"},   32'(resp_valid_o),  32'(eV));
    checkOutput({tag, ".super"},   32'(resp_super_o),  32'(eS));
    checkOutput({tag, ".fault"},   32'(resp_fault_o),  32'(eF));
    checkOutput({tag, ".mode"},    32'(dbg_mode_o),    32'(mSessionLeft > 0));
    checkOutput({tag, ".lockout"}, 32'(dbg_lockout_o), 32'(mLockedOut));
  endtask

  // One clock cycle: drive inputs, predict responses and session state, then check.
  task automatic applyStimulus(input string tag, input logic [1:0] valid, input logic [3:0] priv,
                               input bit dbgReq, input logic [31:0] key, input bit dbgExit);
    logic [1:0] eV, eS, eF;
    bit active;
    int p;
    @(negedge clk_i);
    req_valid_i = valid;
    req_priv_i  = priv;
    dbg_req_i   = dbgReq;
    dbg_key_i   = key;
    dbg_exit_i  = dbgExit;
    active = (mSessionLeft > 0);
    for (int c = 0; c < NUM_CH; c++) begin
      p = int'(priv[2*c +: 2]);
      eV[c] = valid[c];
      eF[c] = valid[c] && (p == 2);
      eS[c] = valid[c] && (p != 2) && ((p == 1) || (active && DBG_CH_MASK[c]));
    end
    if (mLockedOut) begin
    end else if (mPending) begin
      mPending = 1'b0;
      if (mKey == keyRef) begin
        mSessionLeft = TIMEOUT_CYC;
        mFails = 0;
      end else begin
        mFails++;
        if (mFails == MAX_FAIL) mLockedOut = 1'b1;
      end
    end else if (mSessionLeft > 0) begin
      mSessionLeft = dbgExit ? 0 : mSessionLeft - 1;
    end else if (dbgReq) begin
      mPending = 1'b1;
      mKey = key;
    end
    @(posedge clk_i);
    #1;
    checkAll(tag, eV, eS, eF);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 2'b00, 4'b0000, 1'b0, 32'h0, 1'b0);
  endtask

  // Asserts reset between clock edges so the clear is observed asynchronously.
  task automatic doReset(input string tag);
    @(negedge clk_i);
    #2;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_priv_i  = '0;
    dbg_req_i   = 1'b0;
    dbg_key_i   = '0;
    dbg_exit_i  = 1'b0;
    mSessionLeft = 0;
    mFails       = 0;
    mLockedOut   = 1'b0;
    mPending     = 1'b0;
    #1;
    checkAll(tag, 2'b00, 2'b00, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] wrongKey();
    return keyRef ^ 32'($urandom_range(1, 255));
  endfunction

  initial begin
    int cnt;
    keyRef = $urandom;
    dbg_key_ref_i = keyRef;

    #2 rst_ni = 1'b0;
    #1 checkAll("reset_init", 2'b00, 2'b00, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus("ch1_user_nosession", 2'b10, 4'b0000, 1'b0, 32'h0, 1'b0);
    idle("idle0");

    applyStimulus("unlock_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    idle("unlock_check");
    checkOutput("unlock_mode_2cyc", 32'(dbg_mode_o), 32'h1);
    applyStimulus("active_both_user", 2'b11, 4'b0000, 1'b0, 32'h0, 1'b0);
    checkOutput("active_ch1_super", 32'(resp_super_o), 32'h2);
    applyStimulus("active_ch1_rsvd", 2'b10, 4'b1000, 1'b0, 32'h0, 1'b0);
    checkOutput("active_rsvd_fault", 32'(resp_fault_o), 32'h2);
    for (int i = 0; i < 4; i++) idle("drain");

    applyStimulus("tmo_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle("tmo_run");
      if (dbg_mode_o) cnt++;
    end
    checkOutput("session_len", 32'(cnt), 32'd4);

    applyStimulus("exit_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    for (int i = 0; i < 4; i++) idle("exit_run");
    applyStimulus("exit_last", 2'b10, 4'b0000, 1'b0, 32'h0, 1'b1);
    checkOutput("exit_last_grant", 32'(resp_super_o), 32'h2);
    idle("exit_after");
    applyStimulus("exit_relock_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    idle("exit_relock_chk");
    checkOutput("exit_relock_mode", 32'(dbg_mode_o), 32'h1);
    for (int i = 0; i < 5; i++) idle("drain");

    for (int i = 0; i < MAX_FAIL; i++) begin
      applyStimulus("bad_req", 2'b00, 4'b0000, 1'b1, wrongKey(), 1'b0);
      idle("bad_chk");
    end
    checkOutput("lockout_set", 32'(dbg_lockout_o), 32'h1);
    applyStimulus("lockout_good_req", 2'b11, 4'b0101, 1'b1, keyRef, 1'b0);
    idle("lockout_chk");
    idle("lockout_chk2");
    checkOutput("lockout_no_mode", 32'(dbg_mode_o), 32'h0);
    doReset("lockout_reset");
    applyStimulus("post_lock_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    idle("post_lock_chk");
    checkOutput("post_lock_mode", 32'(dbg_mode_o), 32'h1);
    for (int i = 0; i < 5; i++) idle("drain");

    applyStimulus("rst_in_check", 2'b11, 4'b0100, 1'b1, keyRef, 1'b0);
    doReset("rst_async");
    applyStimulus("rst_after_req", 2'b00, 4'b0000, 1'b1, keyRef, 1'b0);
    idle("rst_after_chk");
    checkOutput("rst_after_mode", 32'(dbg_mode_o), 32'h1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset("rand_reset");
      applyStimulus("rand", 2'($urandom), 4'($urandom), $urandom_range(0, 3) == 0,
                    ($urandom_range(0, 1) == 0) ? keyRef : wrongKey(), $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
